// File: rtl/alu_mult_seq.sv
// Sequential unsigned shift-and-add multiplier: one partial-product addition per clock
// through a WIDTH-bit adder, producing a 2*WIDTH-bit product after WIDTH steps.
module alu_mult_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [CntW-1:0]    count_q, count_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // Upper half of acc is the running partial product; lower half shifts out multiplier bits.
  assign addend   = acc_q[0] ? mcand_q : '0;
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_step = {sum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    out_d   = out_q;
    count_d = count_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          mcand_d = in_a;
          acc_d   = {{WIDTH{1'b0}}, in_b};
          count_d = '0;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d   = acc_step;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          out_d   = acc_step;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign out  = out_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: vector table, hand-written corner sequences and
// a randomized run against a product/latency reference model.
module tb_alu_mult_seq;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   in_a, in_b;
  logic           busy, done;
  logic [2*W-1:0] out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] model_out = '0;

  alu_mult_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in_a (in_a),
    .in_b (in_b),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply and follow it to its DONE cycle; returns while done is high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    tick();
    for (int i = 1; i <= W; i++) begin
      check({name, " busy"}, busy, 1);
      check({name, " done low"}, done, 0);
      check({name, " out held"}, out, model_out);
      start = 1'($urandom_range(0, 1));
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      tick();
    end
    start = 1'b0;
    model_out = (2*W)'(a) * (2*W)'(b);
    check({name, " done"}, done, 1);
    check({name, " busy low"}, busy, 0);
    check({name, " product"}, out, model_out);
  endtask

  initial begin
    vec_t vecs[$];
    int   cyc;
    int   done_at;
    logic [2*W-1:0] pend;

    vecs.push_back('{a: 4'd3,  b: 4'd5,  prod: 8'h0F});
    vecs.push_back('{a: 4'd15, b: 4'd15, prod: 8'hE1});
    vecs.push_back('{a: 4'd0,  b: 4'd9,  prod: 8'h00});
    vecs.push_back('{a: 4'd9,  b: 4'd0,  prod: 8'h00});
    vecs.push_back('{a: 4'd1,  b: 4'd1,  prod: 8'h01});
    vecs.push_back('{a: 4'd15, b: 4'd1,  prod: 8'h0F});
    vecs.push_back('{a: 4'd12, b: 4'd10, prod: 8'h78});

    rst = 1'b1; start = 1'b0; in_a = '0; in_b = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset out", out, 0);
      tick();
    end

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, "table");
      check("table const product", out, vecs[i].prod);
      tick();
      check("table back to idle done", done, 0);
      check("table back to idle busy", busy, 0);
      check("table out holds", out, vecs[i].prod);
    end

    // Start while busy must be ignored.
    in_a = 4'd3; in_b = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    in_a = 4'd2; in_b = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy-start still busy", busy, 1);
    tick();
    check("busy-start done", done, 1);
    check("busy-start product", out, 8'h0F);
    model_out = 8'h0F;
    tick();
    check("busy-start no second op", busy, 0);

    // Reset mid-run aborts without a done pulse and clears out.
    in_a = 4'd7; in_b = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort second busy cycle", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_out = '0;
    check("abort out cleared", out, 0);
    for (int i = 0; i < W + 2; i++) begin
      check("abort no done", done, 0);
      check("abort no busy", busy, 0);
      tick();
    end

    // Reset wins over start on the same edge.
    rst = 1'b1; start = 1'b1; in_a = 4'd5; in_b = 4'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst priority busy", busy, 0);
    check("rst priority out", out, 0);

    // Back-to-back: start again during the DONE cycle.
    run_op(4'd5, 4'd5, "b2b first");
    run_op(4'd2, 4'd6, "b2b second");
    check("b2b product 0C", out, 8'h0C);
    tick();

    // Randomized run; first cycles hold start high to cover continuous restarts.
    cyc = 0;
    done_at = -1;
    pend = '0;
    for (int i = 0; i < 300; i++) begin
      start = (i < 3 * (W + 1)) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      if (start && (done_at == -1 || cyc >= done_at)) begin
        done_at = cyc + W + 1;
        pend    = (2*W)'(in_a) * (2*W)'(in_b);
      end
      tick();
      cyc++;
      if (cyc == done_at) model_out = pend;
      check("rand done", done, (cyc == done_at) ? 1 : 0);
      check("rand busy", busy, (done_at != -1 && cyc > done_at - (W + 1) && cyc < done_at) ? 1 : 0);
      check("rand out", out, model_out);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
